vga_scanout: RTL

//  Display-side consumer of the framebuffer read port. Pulls pixels over valid/ready
//  and emits them as a raster with VGA-style hsync/vsync/data-enable timing. Keeps frame

---
 rtl/vga_pkg.sv | 40 ++++
 rtl/vga_timing_gen.sv | 65 ++++++
 rtl/vga_scanout.sv | 117 +++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared raster timing definitions for the VGA scanout block.
package vga_pkg;

   // Default 640x480 @ 60 Hz timing.
   localparam int unsigned PIXEL_W_DEF  = 16;
   localparam int unsigned H_ACTIVE_DEF = 640;
   localparam int unsigned H_FRONT_DEF  = 16;
   localparam int unsigned H_SYNC_DEF   = 96;
   localparam int unsigned H_BACK_DEF   = 48;
   localparam int unsigned V_ACTIVE_DEF = 480;
   localparam int unsigned V_FRONT_DEF  = 10;
   localparam int unsigned V_SYNC_DEF   = 2;
   localparam int unsigned V_BACK_DEF   = 33;

   typedef logic [PIXEL_W_DEF-1:0] pixel_t;

   // Unregistered raster qualifiers for the current counter position.
   // hsync/vsync are logical (1 = inside the sync window), not pin levels.
   typedef struct packed {
      logic active;
      logic hsync;
      logic vsync;
   } raster_t;

   // Total period of one axis: active + front porch + sync + back porch.
   function automatic int unsigned line_total(input int unsigned active,
                                              input int unsigned front,
                                              input int unsigned sync,
                                              input int unsigned back);
      return active + front + sync + back;
   endfunction

   // True when pos lies in [start, start+len).
   function automatic logic in_window(input int unsigned pos,
                                      input int unsigned start,
                                      input int unsigned len);
      return (pos >= start) && (pos < start + len);
   endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical raster counters with unregistered active/sync decode.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int unsigned h_active_p = H_ACTIVE_DEF,
   parameter int unsigned h_front_p  = H_FRONT_DEF,
   parameter int unsigned h_sync_p   = H_SYNC_DEF,
   parameter int unsigned h_back_p   = H_BACK_DEF,
   parameter int unsigned v_active_p = V_ACTIVE_DEF,
   parameter int unsigned v_front_p  = V_FRONT_DEF,
   parameter int unsigned v_sync_p   = V_SYNC_DEF,
   parameter int unsigned v_back_p   = V_BACK_DEF
) (
   input  logic    clk_i,
   input  logic    reset_ni,
   output raster_t raster_o
);

   localparam int unsigned H_TOTAL      = line_total(h_active_p, h_front_p, h_sync_p, h_back_p);
   localparam int unsigned V_TOTAL      = line_total(v_active_p, v_front_p, v_sync_p, v_back_p);
   localparam int unsigned H_W          = $clog2(H_TOTAL);
   localparam int unsigned V_W          = $clog2(V_TOTAL);
   localparam int unsigned H_SYNC_START = h_active_p + h_front_p;
   localparam int unsigned V_SYNC_START = v_active_p + v_front_p;

   localparam logic [H_W-1:0] H_LAST = H_W'(H_TOTAL - 1);
   localparam logic [V_W-1:0] V_LAST = V_W'(V_TOTAL - 1);

   logic [H_W-1:0] h_q, h_d;
   logic [V_W-1:0] v_q, v_d;

   // Next raster position: h wraps every line, v steps on each h wrap.
   always_comb begin
      h_d = h_q + H_W'(1);
      v_d = v_q;
      if (h_q == H_LAST) begin
         h_d = '0;
         if (v_q == V_LAST) begin
            v_d = '0;
         end else begin
            v_d = v_q + V_W'(1);
         end
      end
   end

   // Raster position registers.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         h_q <= '0;
         v_q <= '0;
      end else begin
         h_q <= h_d;
         v_q <= v_d;
      end
   end

   // Decode the current position into active region and sync windows.
   always_comb begin
      raster_o.active = in_window(32'(h_q), 0, h_active_p) &&
                        in_window(32'(v_q), 0, v_active_p);
      raster_o.hsync  = in_window(32'(h_q), H_SYNC_START, h_sync_p);
      raster_o.vsync  = in_window(32'(v_q), V_SYNC_START, v_sync_p);
   end

endmodule

// File: rtl/vga_scanout.sv
// Framebuffer-to-raster scanout: valid/ready pixel intake, underflow debt
// tracking with drain during blanking, and a single output register stage.
module vga_scanout
   import vga_pkg::*;
#(
   parameter int unsigned pixel_width_p = PIXEL_W_DEF,
   parameter int unsigned h_active_p    = H_ACTIVE_DEF,
   parameter int unsigned h_front_p     = H_FRONT_DEF,
   parameter int unsigned h_sync_p      = H_SYNC_DEF,
   parameter int unsigned h_back_p      = H_BACK_DEF,
   parameter int unsigned v_active_p    = V_ACTIVE_DEF,
   parameter int unsigned v_front_p     = V_FRONT_DEF,
   parameter int unsigned v_sync_p      = V_SYNC_DEF,
   parameter int unsigned v_back_p      = V_BACK_DEF,
   parameter bit          sync_pol_p    = 1'b0
) (
   input  logic                     clk_i,
   input  logic                     reset_ni,
   input  logic [pixel_width_p-1:0] pixel_i,
   input  logic                     valid_i,
   output logic                     ready_o,
   output logic [pixel_width_p-1:0] pixel_o,
   output logic                     de_o,
   output logic                     hsync_o,
   output logic                     vsync_o,
   output logic                     underflow_o
);

   // Debt can never exceed one full frame of missed pixels.
   localparam int unsigned DEBT_MAX = h_active_p * v_active_p;
   localparam int unsigned DEBT_W   = $clog2(DEBT_MAX) + 1;
   localparam logic [DEBT_W-1:0] DEBT_SAT = DEBT_W'(DEBT_MAX);

   raster_t ras;

   logic [pixel_width_p-1:0] pixel_q, pixel_d;
   logic                     de_q, de_d;
   logic                     hsync_q, hsync_d;
   logic                     vsync_q, vsync_d;
   logic                     underflow_q, underflow_d;
   logic [DEBT_W-1:0]        debt_q, debt_d;
   logic                     debt_nz;
   logic                     xfer;

   vga_timing_gen #(
      .h_active_p (h_active_p),
      .h_front_p  (h_front_p),
      .h_sync_p   (h_sync_p),
      .h_back_p   (h_back_p),
      .v_active_p (v_active_p),
      .v_front_p  (v_front_p),
      .v_sync_p   (v_sync_p),
      .v_back_p   (v_back_p)
   ) u_timing (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .raster_o (ras)
   );

   // Ready depends only on registered state so upstream never sees a
   // combinational path from valid_i back to ready_o; held low in reset.
   always_comb begin
      debt_nz = (debt_q != '0);
      ready_o = reset_ni && (ras.active || debt_nz);
      xfer    = valid_i && ready_o;
   end

   // Output-stage next state: pass pixel in active slots, count misses as
   // debt, and burn one upstream word per blanking transfer while in debt.
   always_comb begin
      pixel_d     = '0;
      de_d        = ras.active;
      hsync_d     = ras.hsync ? sync_pol_p : ~sync_pol_p;
      vsync_d     = ras.vsync ? sync_pol_p : ~sync_pol_p;
      underflow_d = underflow_q;
      debt_d      = debt_q;
      if (ras.active) begin
         if (valid_i) begin
            pixel_d = pixel_i;
         end else begin
            underflow_d = 1'b1;
            if (debt_q != DEBT_SAT) begin
               debt_d = debt_q + DEBT_W'(1);
            end
         end
      end else if (xfer) begin
         // Outside active, ready_o implies debt_q != 0, so no underflow here.
         debt_d = debt_q - DEBT_W'(1);
      end
   end

   // Output register stage and debt/underflow state.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         pixel_q     <= '0;
         de_q        <= 1'b0;
         hsync_q     <= ~sync_pol_p;
         vsync_q     <= ~sync_pol_p;
         underflow_q <= 1'b0;
         debt_q      <= '0;
      end else begin
         pixel_q     <= pixel_d;
         de_q        <= de_d;
         hsync_q     <= hsync_d;
         vsync_q     <= vsync_d;
         underflow_q <= underflow_d;
         debt_q      <= debt_d;
      end
   end

   assign pixel_o     = pixel_q;
   assign de_o        = de_q;
   assign hsync_o     = hsync_q;
   assign vsync_o     = vsync_q;
   assign underflow_o = underflow_q;

endmodule
